// File: rtl/leaf_port_bank_if.sv
// Bundle of every stream, config and control signal between the leaf interface,
// the soft core and leaf_port_bank. The slave modport is the bank's view; the
// master modport is the view of whatever drives the bank (interface + core).
interface leaf_port_bank_if #(
    parameter int unsigned NUM_IN_PORTS  = 5,
    parameter int unsigned NUM_OUT_PORTS = 5,
    parameter int unsigned PAYLOAD_BITS  = 32,
    parameter int unsigned CFG_ADDR_BITS = 24
);
    logic                                    ap_start;
    // Interface-to-core streams
    logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    in_data;
    logic [NUM_IN_PORTS-1:0]                 in_vld;
    logic [NUM_IN_PORTS-1:0]                 in_rdy;
    logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    core_din;
    logic [NUM_IN_PORTS-1:0]                 core_val_in;
    logic [NUM_IN_PORTS-1:0]                 core_ready_upward;
    // Core-to-interface streams
    logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   core_dout;
    logic [NUM_OUT_PORTS-1:0]                core_val_out;
    logic [NUM_OUT_PORTS-1:0]                core_ready_downward;
    logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   out_data;
    logic [NUM_OUT_PORTS-1:0]                out_vld;
    logic [NUM_OUT_PORTS-1:0]                out_ack;
    // Byte-wide config writes in, word-wide instruction memory writes out
    logic [CFG_ADDR_BITS-1:0]                cfg_addr;
    logic [7:0]                              cfg_din;
    logic                                    cfg_wr_en;
    logic                                    imem_wr_en;
    logic [CFG_ADDR_BITS-3:0]                imem_addr;
    logic [31:0]                             imem_wdata;
    logic [3:0]                              imem_be;
    logic                                    cfg_err;
    logic                                    core_resetn;

    modport slave (
        input  ap_start, in_data, in_vld, core_ready_upward, core_dout, core_val_out, out_ack,
               cfg_addr, cfg_din, cfg_wr_en,
        output in_rdy, core_din, core_val_in, core_ready_downward, out_data, out_vld,
               imem_wr_en, imem_addr, imem_wdata, imem_be, cfg_err, core_resetn
    );

    modport master (
        output ap_start, in_data, in_vld, core_ready_upward, core_dout, core_val_out, out_ack,
               cfg_addr, cfg_din, cfg_wr_en,
        input  in_rdy, core_din, core_val_in, core_ready_downward, out_data, out_vld,
               imem_wr_en, imem_addr, imem_wdata, imem_be, cfg_err, core_resetn
    );
endinterface

// File: rtl/leaf_port_bank.sv
// Port/config front end for a small soft core: one first-word-fall-through FIFO per
// stream channel in each direction, a byte-to-word packer for instruction-config
// writes, and the core's registered active-low reset sequencing.
module leaf_port_bank #(
    parameter int unsigned NUM_IN_PORTS    = 5,
    parameter int unsigned NUM_OUT_PORTS   = 5,
    parameter int unsigned PAYLOAD_BITS    = 32,
    parameter int unsigned FIFO_DEPTH_BITS = 2,
    parameter int unsigned CFG_ADDR_BITS   = 24
) (
    input logic            clk,
    input logic            resetn,
    leaf_port_bank_if.slave bus
);
    localparam int unsigned NumCh    = NUM_IN_PORTS + NUM_OUT_PORTS;
    localparam int unsigned Depth    = 1 << FIFO_DEPTH_BITS;
    localparam int unsigned WordBits = CFG_ADDR_BITS - 2;
    localparam logic [FIFO_DEPTH_BITS:0] DepthCnt = {1'b1, {FIFO_DEPTH_BITS{1'b0}}};

    // Channel array: input streams occupy 0..NUM_IN_PORTS-1, output streams follow.
    logic [PAYLOAD_BITS-1:0] ch_wdata [NumCh];
    logic [PAYLOAD_BITS-1:0] ch_rdata [NumCh];
    logic [NumCh-1:0]        ch_wvld;
    logic [NumCh-1:0]        ch_wrdy;
    logic [NumCh-1:0]        ch_rvld;
    logic [NumCh-1:0]        ch_rrdy;

    for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in_map
        assign ch_wdata[i]                                 = bus.in_data[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        assign ch_wvld[i]                                  = bus.in_vld[i];
        assign ch_rrdy[i]                                  = bus.core_ready_upward[i];
        assign bus.in_rdy[i]                               = ch_wrdy[i];
        assign bus.core_din[i*PAYLOAD_BITS +: PAYLOAD_BITS] = ch_rdata[i];
        assign bus.core_val_in[i]                          = ch_rvld[i];
    end

    for (genvar j = 0; j < NUM_OUT_PORTS; j++) begin : g_out_map
        assign ch_wdata[NUM_IN_PORTS+j]                    = bus.core_dout[j*PAYLOAD_BITS +: PAYLOAD_BITS];
        assign ch_wvld[NUM_IN_PORTS+j]                     = bus.core_val_out[j];
        assign ch_rrdy[NUM_IN_PORTS+j]                     = bus.out_ack[j];
        assign bus.core_ready_downward[j]                  = ch_wrdy[NUM_IN_PORTS+j];
        assign bus.out_data[j*PAYLOAD_BITS +: PAYLOAD_BITS] = ch_rdata[NUM_IN_PORTS+j];
        assign bus.out_vld[j]                              = ch_rvld[NUM_IN_PORTS+j];
    end

    for (genvar c = 0; c < NumCh; c++) begin : g_fifo
        logic [PAYLOAD_BITS-1:0]    mem_q [Depth];
        logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q;
        logic [FIFO_DEPTH_BITS-1:0] rd_ptr_q;
        logic [FIFO_DEPTH_BITS:0]   cnt_q;
        logic                       push;
        logic                       pop;

        // Ready comes only from the registered count, so a full FIFO refuses a push
        // even when it is popped in the same cycle.
        assign ch_wrdy[c]  = (cnt_q != DepthCnt);
        assign ch_rvld[c]  = (cnt_q != '0);
        assign ch_rdata[c] = mem_q[rd_ptr_q];
        assign push        = ch_wvld[c] & ch_wrdy[c];
        assign pop         = ch_rvld[c] & ch_rrdy[c];

        // Storage, pointers and occupancy; memory is cleared so heads read 0 after reset.
        always_ff @(posedge clk) begin
            if (!resetn) begin
                mem_q    <= '{default: '0};
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                if (push) begin
                    mem_q[wr_ptr_q] <= ch_wdata[c];
                    wr_ptr_q        <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
                if (push && !pop) begin
                    cnt_q <= cnt_q + 1'b1;
                end else if (!push && pop) begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    // Config packer state
    logic                buf_valid_q, buf_valid_d;
    logic [WordBits-1:0] buf_word_q, buf_word_d;
    logic [31:0]         buf_data_q, buf_data_d;
    logic [3:0]          buf_mask_q, buf_mask_d;
    logic                flush_pend_q, flush_pend_d;
    logic                ap_start_q;
    logic                cfg_err_q, cfg_err_d;
    logic                imem_wr_en_q, imem_wr_en_d;
    logic [WordBits-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]         imem_wdata_q, imem_wdata_d;
    logic [3:0]          imem_be_q, imem_be_d;
    logic                core_resetn_q, core_resetn_d;

    logic [1:0]          cfg_lane;
    logic [WordBits-1:0] cfg_word;
    logic                flush_req;
    logic [31:0]         merge_data;
    logic [3:0]          merge_mask;
    logic [WordBits-1:0] merge_word;

    assign cfg_lane = bus.cfg_addr[1:0];
    assign cfg_word = bus.cfg_addr[CFG_ADDR_BITS-1:2];

    // Merge incoming bytes, emit full or flushed words, and gate the core reset.
    always_comb begin
        buf_valid_d   = buf_valid_q;
        buf_word_d    = buf_word_q;
        buf_data_d    = buf_data_q;
        buf_mask_d    = buf_mask_q;
        flush_pend_d  = 1'b0;
        cfg_err_d     = cfg_err_q;
        imem_wr_en_d  = 1'b0;
        imem_addr_d   = imem_addr_q;
        imem_wdata_d  = imem_wdata_q;
        imem_be_d     = imem_be_q;
        merge_data    = buf_data_q;
        merge_mask    = buf_mask_q;
        merge_word    = buf_word_q;
        // A flush requested on a write cycle waits until the port is quiet.
        flush_req     = (bus.ap_start & ~ap_start_q) | flush_pend_q;

        if (bus.cfg_wr_en) begin
            if (!buf_valid_q || (cfg_word != buf_word_q)) begin
                // Start a fresh word; a different word while one is open drops it.
                merge_data = '0;
                merge_mask = '0;
                merge_word = cfg_word;
                if (buf_valid_q) begin
                    cfg_err_d = 1'b1;
                end
            end
            merge_data[{cfg_lane, 3'b000} +: 8] = bus.cfg_din;
            merge_mask[cfg_lane]                = 1'b1;
            buf_data_d  = merge_data;
            buf_mask_d  = merge_mask;
            buf_word_d  = merge_word;
            buf_valid_d = 1'b1;
            if (cfg_lane == 2'd3) begin
                imem_wr_en_d = 1'b1;
                imem_addr_d  = merge_word;
                imem_wdata_d = merge_data;
                imem_be_d    = merge_mask;
                buf_valid_d  = 1'b0;
            end
            flush_pend_d = flush_req & buf_valid_d;
        end else if (flush_req && buf_valid_q) begin
            imem_wr_en_d = 1'b1;
            imem_addr_d  = buf_word_q;
            imem_wdata_d = buf_data_q;
            imem_be_d    = buf_mask_q;
            buf_valid_d  = 1'b0;
        end

        // Hold the core in reset while any config word is open or being written.
        core_resetn_d = bus.ap_start &
                        ~(buf_valid_q | buf_valid_d | flush_pend_d | imem_wr_en_d);
    end

    // Packer, config output and core reset registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            buf_valid_q   <= 1'b0;
            buf_word_q    <= '0;
            buf_data_q    <= '0;
            buf_mask_q    <= '0;
            flush_pend_q  <= 1'b0;
            ap_start_q    <= 1'b0;
            cfg_err_q     <= 1'b0;
            imem_wr_en_q  <= 1'b0;
            imem_addr_q   <= '0;
            imem_wdata_q  <= '0;
            imem_be_q     <= '0;
            core_resetn_q <= 1'b0;
        end else begin
            buf_valid_q   <= buf_valid_d;
            buf_word_q    <= buf_word_d;
            buf_data_q    <= buf_data_d;
            buf_mask_q    <= buf_mask_d;
            flush_pend_q  <= flush_pend_d;
            ap_start_q    <= bus.ap_start;
            cfg_err_q     <= cfg_err_d;
            imem_wr_en_q  <= imem_wr_en_d;
            imem_addr_q   <= imem_addr_d;
            imem_wdata_q  <= imem_wdata_d;
            imem_be_q     <= imem_be_d;
            core_resetn_q <= core_resetn_d;
        end
    end

    assign bus.imem_wr_en  = imem_wr_en_q;
    assign bus.imem_addr   = imem_addr_q;
    assign bus.imem_wdata  = imem_wdata_q;
    assign bus.imem_be     = imem_be_q;
    assign bus.cfg_err     = cfg_err_q;
    assign bus.core_resetn = core_resetn_q;
endmodule

// File: tb/tb_leaf_port_bank.sv
// Bench for leaf_port_bank: directed scenarios plus random traffic. Accepted
// stimulus is pushed into per-stream expectation queues; a negedge monitor pops
// and compares whenever the DUT hands something out.
module tb_leaf_port_bank;
    localparam int unsigned NI    = 5;
    localparam int unsigned NO    = 5;
    localparam int unsigned PB    = 32;
    localparam int unsigned FDB   = 2;
    localparam int unsigned AB    = 24;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [AB-3:0] addr;
        logic [31:0]   data;
        logic [3:0]    be;
    } imem_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    leaf_port_bank_if #(
        .NUM_IN_PORTS (NI),
        .NUM_OUT_PORTS(NO),
        .PAYLOAD_BITS (PB),
        .CFG_ADDR_BITS(AB)
    ) bus ();

    leaf_port_bank #(
        .NUM_IN_PORTS   (NI),
        .NUM_OUT_PORTS  (NO),
        .PAYLOAD_BITS   (PB),
        .FIFO_DEPTH_BITS(FDB),
        .CFG_ADDR_BITS  (AB)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    logic [PB-1:0] exp_in  [NI][$];
    logic [PB-1:0] exp_out [NO][$];
    imem_t         exp_imem [$];
    int checks = 0;
    int errors = 0;

    // Config reference: one open word as a byte array plus a lane mask.
    logic          m_valid, m_err, m_pend, m_ap_prev;
    logic [AB-3:0] m_word;
    logic [7:0]    m_bytes [4];
    logic [3:0]    m_mask;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) exp_in[i].delete();
        for (int j = 0; j < NO; j++) exp_out[j].delete();
        exp_imem.delete();
        m_valid   = 1'b0;
        m_err     = 1'b0;
        m_pend    = 1'b0;
        m_ap_prev = 1'b0;
        m_mask    = 4'h0;
        m_word    = '0;
    endtask

    task automatic model_emit();
        imem_t e;
        e.addr  = m_word;
        e.data  = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
        e.be    = m_mask;
        exp_imem.push_back(e);
        m_valid = 1'b0;
    endtask

    // Called late in each cycle: note every transfer that the coming edge performs.
    task automatic record();
        logic          rise;
        logic [AB-3:0] word;
        int            lane;
        if (!resetn) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NI; i++)
            if (bus.in_vld[i] && bus.in_rdy[i]) exp_in[i].push_back(bus.in_data[i*PB +: PB]);
        for (int j = 0; j < NO; j++)
            if (bus.core_val_out[j] && bus.core_ready_downward[j])
                exp_out[j].push_back(bus.core_dout[j*PB +: PB]);
        rise      = bus.ap_start && !m_ap_prev;
        m_ap_prev = bus.ap_start;
        if (bus.cfg_wr_en) begin
            word = bus.cfg_addr[AB-1:2];
            lane = int'(bus.cfg_addr[1:0]);
            if (m_valid && word != m_word) begin
                m_err   = 1'b1;
                m_valid = 1'b0;
            end
            if (!m_valid) begin
                m_valid = 1'b1;
                m_word  = word;
                m_mask  = 4'h0;
                for (int b = 0; b < 4; b++) m_bytes[b] = 8'h00;
            end
            m_bytes[lane] = bus.cfg_din;
            m_mask[lane]  = 1'b1;
            if (lane == 3) model_emit();
            m_pend = (rise || m_pend) && m_valid;
        end else begin
            if ((rise || m_pend) && m_valid) model_emit();
            m_pend = 1'b0;
        end
    endtask

    // Inputs are driven at posedge+1; transfers are recorded at posedge+8.
    task automatic tick();
        #7;
        record();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [AB-1:0] a, input logic [7:0] d);
        bus.cfg_wr_en = 1'b1;
        bus.cfg_addr  = a;
        bus.cfg_din   = d;
        tick();
        bus.cfg_wr_en = 1'b0;
    endtask

    task automatic idle();
        bus.in_vld            = '0;
        bus.core_val_out      = '0;
        bus.core_ready_upward = '0;
        bus.out_ack           = '0;
        bus.cfg_wr_en         = 1'b0;
    endtask

    task automatic rand_cycle();
        for (int i = 0; i < NI; i++) bus.in_data[i*PB +: PB] = $urandom;
        for (int j = 0; j < NO; j++) bus.core_dout[j*PB +: PB] = $urandom;
        bus.in_vld            = NI'($urandom);
        bus.core_ready_upward = NI'($urandom);
        bus.core_val_out      = NO'($urandom);
        bus.out_ack           = NO'($urandom);
        bus.cfg_wr_en         = ($urandom_range(0, 3) == 0);
        bus.cfg_addr          = AB'(32'h4000 + $urandom_range(0, 11));
        bus.cfg_din           = 8'($urandom);
        if ($urandom_range(0, 19) == 0) bus.ap_start = ~bus.ap_start;
        tick();
    endtask

    // Monitor: occupancy-derived ready/valid, and every value handed out by the DUT.
    always @(negedge clk) begin
        if (resetn) begin
            for (int i = 0; i < NI; i++) begin
                check($sformatf("in_rdy[%0d]", i), bus.in_rdy[i], exp_in[i].size() < DEPTH);
                check($sformatf("core_val_in[%0d]", i), bus.core_val_in[i], exp_in[i].size() > 0);
                if (bus.core_val_in[i] && bus.core_ready_upward[i] && exp_in[i].size() > 0)
                    check($sformatf("core_din[%0d]", i), bus.core_din[i*PB +: PB],
                          exp_in[i].pop_front());
            end
            for (int j = 0; j < NO; j++) begin
                check($sformatf("core_ready_downward[%0d]", j), bus.core_ready_downward[j],
                      exp_out[j].size() < DEPTH);
                check($sformatf("out_vld[%0d]", j), bus.out_vld[j], exp_out[j].size() > 0);
                if (bus.out_vld[j] && bus.out_ack[j] && exp_out[j].size() > 0)
                    check($sformatf("out_data[%0d]", j), bus.out_data[j*PB +: PB],
                          exp_out[j].pop_front());
            end
            if (bus.imem_wr_en) begin
                if (exp_imem.size() == 0) begin
                    check("imem_unexpected_pulse", bus.imem_wr_en, 1'b0);
                end else begin
                    imem_t e;
                    e = exp_imem.pop_front();
                    check("imem_addr", bus.imem_addr, e.addr);
                    check("imem_wdata", bus.imem_wdata, e.data);
                    check("imem_be", bus.imem_be, e.be);
                end
            end
            check("cfg_err", bus.cfg_err, m_err);
        end
    end

    initial begin
        logic [PB-1:0] vals [4];
        int            left;
        vals = '{32'h11, 32'h22, 32'h33, 32'h44};
        model_reset();
        bus.ap_start  = 1'b0;
        bus.in_data   = '0;
        bus.core_dout = '0;
        bus.cfg_addr  = '0;
        bus.cfg_din   = '0;
        idle();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_rdy", bus.in_rdy, 5'h1f);
        check("rst_core_val_in", bus.core_val_in, 0);
        check("rst_out_vld", bus.out_vld, 0);
        check("rst_core_ready_downward", bus.core_ready_downward, 5'h1f);
        check("rst_core_din_lo", bus.core_din[63:0], 0);
        check("rst_out_data_lo", bus.out_data[63:0], 0);
        check("rst_imem_wr_en", bus.imem_wr_en, 0);
        check("rst_imem_be", bus.imem_be, 0);
        check("rst_imem_addr", bus.imem_addr, 0);
        check("rst_imem_wdata", bus.imem_wdata, 0);
        check("rst_cfg_err", bus.cfg_err, 0);
        check("rst_core_resetn", bus.core_resetn, 0);
        resetn = 1'b1;
        tick();

        // Fill channel 2 with the core stalled.
        for (int k = 0; k < 4; k++) begin
            bus.in_vld               = 5'b00100;
            bus.in_data[2*PB +: PB]  = vals[k];
            tick();
            if (k == 0) begin
                check("first_push_valid", bus.core_val_in[2], 1);
                check("first_push_head", bus.core_din[2*PB +: PB], 32'h11);
            end
        end
        check("full_in_rdy", bus.in_rdy[2], 0);

        // Push while full plus pop, with traffic on every other channel.
        for (int i = 0; i < NI; i++) bus.in_data[i*PB +: PB] = $urandom;
        bus.in_data[2*PB +: PB] = 32'h55;
        bus.in_vld              = 5'b11111;
        bus.core_ready_upward   = 5'b11111;
        tick();
        bus.in_vld = '0;
        check("rdy_after_full_pop", bus.in_rdy[2], 1);
        check("head_after_full_pop", bus.core_din[2*PB +: PB], 32'h22);
        repeat (3) tick();
        bus.core_ready_upward = '0;
        check("ch2_empty", bus.core_val_in[2], 0);
        idle();
        tick();

        // Full word packed from four bytes.
        cfg_write(24'h000100, 8'hAA);
        cfg_write(24'h000101, 8'hBB);
        cfg_write(24'h000102, 8'hCC);
        cfg_write(24'h000103, 8'hDD);
        check("word_pulse", bus.imem_wr_en, 1);
        check("word_addr", bus.imem_addr, 22'h40);
        check("word_wdata", bus.imem_wdata, 32'hDDCCBBAA);
        check("word_be", bus.imem_be, 4'hf);
        tick();
        check("word_pulse_single", bus.imem_wr_en, 0);
        check("word_wdata_held", bus.imem_wdata, 32'hDDCCBBAA);

        // Partial word flushed by ap_start; core reset released one cycle after.
        cfg_write(24'h000200, 8'h5A);
        cfg_write(24'h000201, 8'hC3);
        tick();
        bus.ap_start = 1'b1;
        tick();
        check("flush_pulse", bus.imem_wr_en, 1);
        check("flush_addr", bus.imem_addr, 22'h80);
        check("flush_be", bus.imem_be, 4'h3);
        check("flush_wdata", bus.imem_wdata, 32'h0000C35A);
        check("core_resetn_held", bus.core_resetn, 0);
        tick();
        check("core_resetn_rise", bus.core_resetn, 1);
        bus.ap_start = 1'b0;
        tick();
        check("core_resetn_fall", bus.core_resetn, 0);

        // Write coinciding with the ap_start rise defers the flush.
        bus.ap_start = 1'b1;
        cfg_write(24'h000300, 8'h77);
        check("deferred_no_pulse", bus.imem_wr_en, 0);
        tick();
        check("deferred_pulse", bus.imem_wr_en, 1);
        check("deferred_addr", bus.imem_addr, 22'hC0);
        check("deferred_be", bus.imem_be, 4'h1);
        bus.ap_start = 1'b0;
        tick();

        // Word change discards the open word and sets the sticky error.
        cfg_write(24'h000010, 8'h01);
        cfg_write(24'h000024, 8'h02);
        check("err_set", bus.cfg_err, 1);
        check("err_no_pulse", bus.imem_wr_en, 0);
        cfg_write(24'h000027, 8'h03);
        check("err_word_pulse", bus.imem_wr_en, 1);
        check("err_word_addr", bus.imem_addr, 22'h09);
        check("err_word_be", bus.imem_be, 4'h9);
        check("err_word_wdata", bus.imem_wdata, 32'h03000002);
        check("err_sticky", bus.cfg_err, 1);

        repeat (400) rand_cycle();

        // Half-fill everything, then reset mid-traffic.
        idle();
        bus.ap_start          = 1'b1;
        bus.core_ready_upward = '1;
        bus.out_ack           = '1;
        repeat (6) tick();
        idle();
        bus.in_vld       = '1;
        bus.core_val_out = '1;
        repeat (2) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        idle();
        check("midrst_core_val_in", bus.core_val_in, 0);
        check("midrst_out_vld", bus.out_vld, 0);
        check("midrst_in_rdy", bus.in_rdy, 5'h1f);
        check("midrst_core_ready_downward", bus.core_ready_downward, 5'h1f);
        check("midrst_core_resetn", bus.core_resetn, 0);
        tick();

        repeat (300) rand_cycle();

        // Drain everything still queued.
        idle();
        bus.core_ready_upward = '1;
        bus.out_ack           = '1;
        repeat (12) tick();
        left = exp_imem.size();
        for (int i = 0; i < NI; i++) left += exp_in[i].size();
        for (int j = 0; j < NO; j++) left += exp_out[j].size();
        check("undelivered_items", left, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/leaf_port_bank.md
Name: leaf_port_bank

Overview:
- Parametrised port/config front end between a leaf interface and a soft core (picorv32-class), replacing fixed 5-in/5-out hard wiring.
- Provides one FIFO per input and per output stream port, with generic channel count, width and depth.
- Packs the leaf interface's byte-wide instruction-config writes into word writes with byte enables.
- Sequences the core's active-low reset from ap_start and config state.

Parameters:
- NUM_IN_PORTS, 5, number of interface-to-core stream channels (1..16).
- NUM_OUT_PORTS, 5, number of core-to-interface stream channels (1..16).
- PAYLOAD_BITS, 32, stream word width.
- FIFO_DEPTH_BITS, 2, log2 of per-channel FIFO depth (depth 4 by default, minimum 1).
- CFG_ADDR_BITS, 24, byte-address width of the config write port.

Ports:
- clk  in  1  single clock for the whole block.
- resetn  in  1  synchronous, active-low reset.
- ap_start  in  1  core run request, level.
- in_data  in  NUM_IN_PORTS*PAYLOAD_BITS  interface-to-core data; channel i at [i*PAYLOAD_BITS +: PAYLOAD_BITS].
- in_vld  in  NUM_IN_PORTS  per-channel valid from the interface.
- in_rdy  out  NUM_IN_PORTS  per-channel ready to the interface.
- core_din  out  NUM_IN_PORTS*PAYLOAD_BITS  FIFO head to the core.
- core_val_in  out  NUM_IN_PORTS  head valid.
- core_ready_upward  in  NUM_IN_PORTS  core pops the head.
- core_dout  in  NUM_OUT_PORTS*PAYLOAD_BITS  core output data.
- core_val_out  in  NUM_OUT_PORTS  core output valid.
- core_ready_downward  out  NUM_OUT_PORTS  core output ready.
- out_data  out  NUM_OUT_PORTS*PAYLOAD_BITS  data to the interface.
- out_vld  out  NUM_OUT_PORTS  valid to the interface.
- out_ack  in  NUM_OUT_PORTS  interface accepts.
- cfg_addr  in  CFG_ADDR_BITS  config byte address.
- cfg_din  in  8  config byte.
- cfg_wr_en  in  1  config byte strobe.
- imem_wr_en  out  1  word-write pulse.
- imem_addr  out  CFG_ADDR_BITS-2  word address.
- imem_wdata  out  32  packed word.
- imem_be  out  4  byte enables.
- cfg_err  out  1  sticky: a partial word was discarded.
- core_resetn  out  1  registered active-low reset to the core.

Behaviour:
- All state resets synchronously when resetn=0 at a clk edge. After reset:
  - all FIFOs are empty; in_rdy is all ones; core_val_in, out_vld, imem_wr_en, imem_be and cfg_err are 0.
  - core_ready_downward is all ones; core_din, out_data, imem_addr and imem_wdata are 0; core_resetn is 0.
- FIFOs: one identical instance per channel, depth 2^FIFO_DEPTH_BITS, first-word fall-through.
  - A transfer occurs in a cycle where valid=1 and ready=1. Input side: in_vld/in_rdy. Output side: core_val_out/core_ready_downward.
  - ready = !full, taken from the registered count. When the FIFO is full, a push is refused even if a pop occurs in the same cycle.
  - Push into an empty FIFO: valid is asserted and the data is visible the next cycle (latency 1). There is no combinational path from input to output.
  - A pop occurs when valid=1 and the downstream ready/ack=1 (core_ready_upward or out_ack). Simultaneous push and pop when not full or empty leaves the count unchanged.
  - Pointers wrap modulo depth. The count is FIFO_DEPTH_BITS+1 bits wide.
  - Data order is preserved. Channels are fully independent.
- Config packer: buffer holding word address W, data, byte mask M and flag buf_valid.
  - On cfg_wr_en, lane L = cfg_addr[1:0] and word = cfg_addr[CFG_ADDR_BITS-1:2].
  - If buf_valid is set and word != W: the old partial word is discarded, cfg_err is set, and the buffer restarts with the new byte.
  - Otherwise byte L is merged (a repeat write to a lane overwrites it) and M[L] is set.
  - If L==3: emit in the next cycle imem_wr_en=1, imem_addr=W, imem_wdata=merged data (masked lanes 0), imem_be=M|4'b1000; clear buf_valid.
  - On an ap_start rising edge (registered compare) with buf_valid set and no cfg_wr_en that cycle: flush the partial word with imem_be=M.
  - If cfg_wr_en coincides with an ap_start rising edge, the write is processed and the flush is deferred while buf_valid remains set.
  - imem_wr_en is a single-cycle pulse. imem_wdata, imem_addr and imem_be hold their values between pulses.
- core_resetn is registered as resetn & ap_start & !buf_valid & !(imem flush pending).
  - It rises at least 1 cycle after the last config emission.
  - It falls 1 cycle after ap_start falls.
  - Falling ap_start does not clear the FIFOs.

Test Plan:
- Reset, then NUM_IN=5/depth 4: push 0x11,0x22,0x33,0x44 on channel 2 with core_ready_upward=0 → in_rdy[2]=0 after the 4th push. Then pop → order 11,22,33,44 with valid one cycle after the first push.
- Full FIFO with in_vld and pop in the same cycle → push refused, count 3, in_rdy rises next cycle. Concurrent traffic on the other 4 channels is unaffected.
- cfg bytes AA,BB,CC,DD at addresses 0x100..0x103 → one pulse, imem_addr=0x40, wdata=0xDDCCBBAA, be=1111.
- Bytes at 0x200 and 0x201, then ap_start 0→1 → flush pulse with addr=0x80, be=0011, wdata=0x0000xxyy. core_resetn rises 1 cycle later, not earlier.
- A byte at 0x10 then a byte at 0x24 → cfg_err=1 sticky, no pulse. A following write to 0x27 emits addr=0x09, be=1001.
- resetn=0 mid-traffic with FIFOs half full → next cycle all valids are 0, in_rdy is all ones, and core_resetn=0.
